// File: rtl/sha256_msg_sched.sv
// ============================================================================
// Module   : sha256_msg_sched
// Brief    : SHA-256 message-schedule expander. It reads W[0..15] from word memory,
//            then writes W[16..63] back to memory. The optional ABORT input is
//            enabled by defining MSCHED_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_sched #(
  parameter int              ADDR_W    = 15,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 15'h0040
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
`ifdef MSCHED_ABORT_EN
  input  logic              abort_i,
`endif
  input  logic              start_i,
  input  logic [31:0]       d_read_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] a_o,
  output logic [31:0]       d_write_o,
  output logic              oe_o,
  output logic              we_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EXPAND = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       win_q [16];
  logic [31:0]       win_d [16];
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       d_write_q, d_write_d;
  logic              oe_q, oe_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic              shift_en;
  logic [31:0]       shift_word;
  logic [31:0]       w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      a_q       <= '0;
      d_write_q <= '0;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      a_q       <= a_d;
      d_write_q <= d_write_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // LOAD index k runs 0..16 and hands over to EXPAND at t=16, so one counter covers both phases.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_en   = 1'b0;
    shift_word = d_read_i;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        shift_en = (idx_q != 6'd0);
        if (idx_q == 6'd16) state_d = ST_EXPAND;
        else                idx_d   = idx_q + 6'd1;
      end
      ST_EXPAND: begin
        shift_en   = 1'b1;
        shift_word = d_write_q;
        if (idx_q == 6'd63) state_d = ST_DONE;
        else                idx_d   = idx_q + 6'd1;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MSCHED_ABORT_EN
    if (abort_i && (state_q == ST_LOAD || state_q == ST_EXPAND)) state_d = ST_IDLE;
`endif
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (shift_en) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
      win_d[15] = shift_word;
    end
  end

  // win_d holds W[t-16..t-1] at the edge entering cycle t, so the registered write data is W[t].
  assign w_next = sig1(win_d[14]) + win_d[9] + sig0(win_d[1]) + win_d[0];

  always_comb begin
    a_d       = a_q;
    d_write_d = d_write_q;
    oe_d      = 1'b1;
    we_d      = 1'b1;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    case (state_d)
      ST_LOAD: begin
        a_d  = BASE_ADDR + ADDR_W'(idx_d);
        oe_d = (idx_d == 6'd16);
      end
      ST_EXPAND: begin
        a_d       = BASE_ADDR + ADDR_W'(idx_d);
        d_write_d = w_next;
        we_d      = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign a_o       = a_q;
  assign d_write_o = d_write_q;
  assign oe_o      = oe_q;
  assign we_o      = we_q;

endmodule

`default_nettype wire
